// File: rtl/uart_rx_word_fifo.sv
// UART byte-to-word assembler feeding a show-ahead word FIFO with sticky overflow.
// Optional partial-word idle timeout is built only when UART_RX_FIFO_TIMEOUT_EN is defined.
module uart_rx_word_fifo #(
    parameter int BYTES_PER_WORD = 4,
    parameter int DEPTH_LOG2     = 3,
    parameter int BIG_ENDIAN     = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        CLK,
    input  logic                        reset_n,
    input  logic [7:0]                  byte_data,
    input  logic                        byte_valid,
    input  logic                        flush,
    input  logic                        pop,
    output logic [8*BYTES_PER_WORD-1:0] word_data,
    output logic                        word_valid,
    output logic [DEPTH_LOG2:0]         count,
    output logic                        overflow,
    output logic                        timeout
);
    localparam int W     = 8 * BYTES_PER_WORD;
    localparam int IDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      lane;
    logic [W-1:0]          asm_q;
    logic [W-1:0]          asm_next;
    logic [W-1:0]          mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  last_byte;
    logic                  push_req;
    logic                  do_push;
    logic                  do_pop;
    logic                  full;
    logic                  tmo_fire;

    assign lane = (BIG_ENDIAN != 0) ? (LAST_IDX - idx) : idx;

    // The completed word is pushed from the combinational next value so the
    // final byte lands in the FIFO on the same edge it is captured.
    always_comb begin
        asm_next = asm_q;
        if (byte_valid)
            asm_next[lane*8 +: 8] = byte_data;
    end

    assign last_byte = byte_valid && (idx == LAST_IDX);
    assign push_req  = last_byte && !flush;
    assign full      = (count == FULL_CNT);
    assign do_pop    = pop && (count != '0) && !flush;
    assign do_push   = push_req && (!full || do_pop);

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            idx   <= '0;
            asm_q <= '0;
        end else if (flush) begin
            idx <= '0;
        end else if (byte_valid) begin
            asm_q <= asm_next;
            idx   <= last_byte ? '0 : idx + 1'b1;
        end else if (tmo_fire) begin
            idx <= '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push)
            mem[wr_ptr] <= asm_next;
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
            if (push_req && !do_push)
                overflow <= 1'b1;
        end
    end

    assign word_data  = mem[rd_ptr];
    assign word_valid = (count != '0);

`ifdef UART_RX_FIFO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] idle_cnt;

    // Fires on the TIMEOUT_CYCLES-th consecutive idle cycle of a partial word.
    assign tmo_fire = !byte_valid && (idx != '0) && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt <= '0;
            timeout  <= 1'b0;
        end else if (flush) begin
            idle_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= tmo_fire;
            if (byte_valid || (idx == '0) || tmo_fire)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign tmo_fire           = 1'b0;
    assign timeout            = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_word_fifo.sv
// Scoreboard bench: a big-endian depth-2 instance and a little-endian depth-8
// instance share one byte stream; expected words are queued per instance.
module tb_uart_rx_word_fifo;
    logic        CLK = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_valid = 1'b0;
    logic        flush = 1'b0;
    logic        pop = 1'b0;
    logic [31:0] wd_a, wd_b;
    logic        wv_a, wv_b, ovf_a, ovf_b, tmo_a, tmo_b;
    logic [1:0]  cnt_a;
    logic [3:0]  cnt_b;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] q_a[$];
    logic [31:0] q_b[$];
    logic [31:0] part_a = '0;
    logic [31:0] part_b = '0;
    int          idx_m = 0;
    logic        ovf_ma = 1'b0;
    logic        ovf_mb = 1'b0;

    always #5 CLK = ~CLK;

    uart_rx_word_fifo #(.BYTES_PER_WORD(4), .DEPTH_LOG2(1), .BIG_ENDIAN(1), .TIMEOUT_CYCLES(16)) u_dut_a (
        .CLK(CLK), .reset_n(reset_n), .byte_data(byte_data), .byte_valid(byte_valid),
        .flush(flush), .pop(pop), .word_data(wd_a), .word_valid(wv_a), .count(cnt_a),
        .overflow(ovf_a), .timeout(tmo_a)
    );

    uart_rx_word_fifo #(.BYTES_PER_WORD(4), .DEPTH_LOG2(3), .BIG_ENDIAN(0), .TIMEOUT_CYCLES(16)) u_dut_b (
        .CLK(CLK), .reset_n(reset_n), .byte_data(byte_data), .byte_valid(byte_valid),
        .flush(flush), .pop(pop), .word_data(wd_b), .word_valid(wv_b), .count(cnt_b),
        .overflow(ovf_b), .timeout(tmo_b)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_outs();
        chk("wv_a", wv_a, q_a.size() != 0);
        chk("cnt_a", cnt_a, q_a.size());
        chk("ovf_a", ovf_a, ovf_ma);
        if (q_a.size() != 0) chk("head_a", wd_a, q_a[0]);
        chk("wv_b", wv_b, q_b.size() != 0);
        chk("cnt_b", cnt_b, q_b.size());
        chk("ovf_b", ovf_b, ovf_mb);
        if (q_b.size() != 0) chk("head_b", wd_b, q_b[0]);
    endtask

    task automatic clear_model();
        q_a.delete();
        q_b.delete();
        idx_m  = 0;
        ovf_ma = 1'b0;
        ovf_mb = 1'b0;
    endtask

    // One clock: drive at negedge, update the model, check at the next negedge.
    task automatic tick(input logic bv, input logic [7:0] b, input logic p, input logic f);
        byte_valid = bv;
        byte_data  = b;
        pop        = p;
        flush      = f;
        if (f) begin
            clear_model();
        end else begin
            if (p && q_a.size() != 0) begin
                chk("pop_a", wd_a, q_a[0]);
                void'(q_a.pop_front());
            end
            if (p && q_b.size() != 0) begin
                chk("pop_b", wd_b, q_b[0]);
                void'(q_b.pop_front());
            end
            if (bv) begin
                part_a[(3-idx_m)*8 +: 8] = b;
                part_b[idx_m*8 +: 8]     = b;
                if (idx_m == 3) begin
                    if (q_a.size() < 2) q_a.push_back(part_a); else ovf_ma = 1'b1;
                    if (q_b.size() < 8) q_b.push_back(part_b); else ovf_mb = 1'b1;
                    idx_m = 0;
                end else begin
                    idx_m++;
                end
            end
        end
        @(posedge CLK);
        @(negedge CLK);
        byte_valid = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;
        check_outs();
    endtask

    task automatic send_word(input logic [31:0] w, input logic pop_last);
        tick(1'b1, w[31:24], 1'b0, 1'b0);
        tick(1'b1, w[23:16], 1'b0, 1'b0);
        tick(1'b1, w[15:8],  1'b0, 1'b0);
        tick(1'b1, w[7:0],   pop_last, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        reset_n = 1'b0;
        #1;
        chk("rst_wv_a", wv_a, 1'b0);
        chk("rst_cnt_a", cnt_a, 0);
        chk("rst_ovf_a", ovf_a, 1'b0);
        chk("rst_tmo_a", tmo_a, 1'b0);
        chk("rst_cnt_b", cnt_b, 0);
        clear_model();
        @(posedge CLK);
        @(negedge CLK);
        reset_n = 1'b1;
        check_outs();
    endtask

    initial begin
        int pulses_a;
        int pulses_b;
        int exp_pulses;

        do_reset();

        // Basic assembly in both byte orders
        send_word(32'h12345678, 1'b0);
        chk("be_word", wd_a, 32'h12345678);
        chk("le_word", wd_b, 32'h78563412);
        chk("be_cnt1", cnt_a, 1);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pop_empty_cnt", cnt_a, 0);
        chk("pop_empty_wv", wv_a, 1'b0);
        tick(1'b0, 8'h00, 1'b1, 1'b0);

        // Overflow on the depth-2 instance
        send_word(32'h00000001, 1'b0);
        send_word(32'h00000002, 1'b0);
        send_word(32'h00000003, 1'b0);
        chk("ovf_cnt", cnt_a, 2);
        chk("ovf_set", ovf_a, 1'b1);
        chk("deep_no_ovf", ovf_b, 1'b0);
        chk("first_pop", wd_a, 32'h00000001);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        chk("second_pop", wd_a, 32'h00000002);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        send_word(32'h00000004, 1'b0);
        send_word(32'h00000005, 1'b0);
        send_word(32'h00000009, 1'b1);
        chk("full_pp_cnt", cnt_a, 2);
        chk("full_pp_ovf", ovf_a, 1'b1);
        chk("full_pp_head", wd_a, 32'h00000005);

        // Reset mid-word discards the partial word
        tick(1'b1, 8'h01, 1'b0, 1'b0);
        tick(1'b1, 8'h02, 1'b0, 1'b0);
        do_reset();
        send_word(32'hAABBCCDD, 1'b0);
        chk("rst_midword", wd_a, 32'hAABBCCDD);

        // Flush mid-word, with competing byte and pop, clears overflow
        send_word(32'h00000010, 1'b0);
        send_word(32'h00000011, 1'b0);
        chk("ovf_again", ovf_a, 1'b1);
        tick(1'b1, 8'h01, 1'b0, 1'b0);
        tick(1'b1, 8'h02, 1'b0, 1'b0);
        tick(1'b1, 8'hEE, 1'b1, 1'b1);
        chk("flush_cnt", cnt_a, 0);
        send_word(32'hAABBCCDD, 1'b0);
        chk("flush_midword", wd_a, 32'hAABBCCDD);
        chk("flush_ovf", ovf_a, 1'b0);
        chk("flush_cnt1", cnt_a, 1);

        // Partial-word idle timeout
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        tick(1'b1, 8'h11, 1'b0, 1'b0);
        pulses_a = 0;
        pulses_b = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 8'h00, 1'b0, 1'b0);
            if (tmo_a === 1'b1) pulses_a++;
            if (tmo_b === 1'b1) pulses_b++;
        end
`ifdef UART_RX_FIFO_TIMEOUT_EN
        exp_pulses = 1;
        idx_m = 0;
`else
        exp_pulses = 0;
`endif
        chk("tmo_pulses_a", pulses_a, exp_pulses);
        chk("tmo_pulses_b", pulses_b, exp_pulses);
        send_word(32'hA1A2A3A4, 1'b0);
`ifdef UART_RX_FIFO_TIMEOUT_EN
        chk("tmo_word", wd_a, 32'hA1A2A3A4);
`else
        chk("hold_word", wd_a, 32'h11A1A2A3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_word_fifo.md
UART_RX_WORD_FIFO -- requirements
Module: uart_rx_word_fifo

Interface
REQ-001 SHALL have parameter BYTES_PER_WORD, default 4, bytes assembled per word (range 1..8).
REQ-002 SHALL have parameter DEPTH_LOG2, default 3, FIFO depth = 2**DEPTH_LOG2 words (range 1..8).
REQ-003 SHALL have parameter BIG_ENDIAN, default 1: 1 = first byte lands in word MSB; 0 = first byte lands in LSB.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, idle-cycle limit for a partial word (range 1..2**20).
REQ-005 CLK  input  1  sole clock, rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 byte_data  input  8  received UART byte.
REQ-008 byte_valid  input  1  single-cycle strobe qualifying byte_data.
REQ-009 flush  input  1  synchronous clear of assembler, FIFO and overflow.
REQ-010 pop  input  1  consumer removes the head word.
REQ-011 word_data  output  8*BYTES_PER_WORD  head word, show-ahead.
REQ-012 word_valid  output  1  FIFO non-empty.
REQ-013 count  output  DEPTH_LOG2+1  words held, 0..2**DEPTH_LOG2.
REQ-014 overflow  output  1  sticky: a completed word was dropped.
REQ-015 timeout  output  1  one-cycle pulse: a partial word was discarded.

Function
REQ-016 Assembler SHALL hold a byte index 0..BYTES_PER_WORD-1; each byte_valid stores byte_data at the lane selected by index and BIG_ENDIAN, then increments the index.
REQ-017 On the byte_valid with index = BYTES_PER_WORD-1, the completed word SHALL be pushed on the same edge and the index SHALL wrap to 0.
REQ-018 word_valid SHALL assert in the cycle after the edge capturing the final byte (latency 1) when the FIFO was empty.
REQ-019 word_data SHALL equal the oldest stored word whenever word_valid=1; value is don't-care when word_valid=0.
REQ-020 pop with word_valid=1 SHALL remove the head on that edge; pop with word_valid=0 SHALL be ignored.
REQ-021 Push while count = 2**DEPTH_LOG2 and no pop SHALL drop the word, leave FIFO unchanged, set overflow; the assembler still wraps to 0.
REQ-022 Push and pop on the same edge SHALL both succeed with count unchanged, including when full or when count = 1.
REQ-023 Read/write pointers SHALL be DEPTH_LOG2 bits and wrap modulo depth; count SHALL derive from push/pop, never exceed depth, never underflow.
REQ-024 flush SHALL, on the edge it is sampled, zero index, count, pointers and overflow; flush SHALL take priority over byte_valid and pop in the same cycle.
REQ-025 overflow SHALL stay set until flush or reset.
REQ-026 timeout SHALL be 0 except as defined in REQ-030.

Reset
REQ-027 reset_n=0 SHALL immediately and asynchronously force index=0, pointers=0, count=0, word_valid=0, overflow=0, timeout=0, idle counter=0.
REQ-028 Assertion of reset_n mid-word SHALL discard the partial word; FIFO storage contents need not be cleared.
REQ-029 Deassertion SHALL be accepted on any edge; first byte_valid sampled after deassertion is index 0.

Configuration
REQ-030 With UART_RX_FIFO_TIMEOUT_EN defined: an idle counter SHALL count cycles with index != 0 and byte_valid=0, clear on any byte_valid or when index = 0; on reaching TIMEOUT_CYCLES it SHALL force index to 0 and pulse timeout for exactly one cycle; a byte_valid in that same cycle SHALL win (stored, counter cleared, no timeout).
REQ-031 Without UART_RX_FIFO_TIMEOUT_EN: no idle counter SHALL be built, timeout SHALL be tied 0, and a partial word SHALL be held indefinitely.

Verification
REQ-032 Defaults; bytes 0x12,0x34,0x56,0x78 -> word_valid next cycle, word_data=0x12345678, count=1; pop -> count=0, word_valid=0.
REQ-033 BIG_ENDIAN=0, same bytes -> word_data=0x78563412.
REQ-034 DEPTH_LOG2=1; push 3 words (0x00000001..0x00000003) without pop -> count=2, overflow=1, pops return 1 then 2; 9th word pushed with simultaneous pop while full -> count stays 2, overflow unchanged.
REQ-035 Send 2 bytes, assert reset_n=0 for one cycle, send 0xAABBCCDD bytes -> word_data=0xAABBCCDD; same with flush instead of reset -> same result, overflow cleared.
REQ-036 Macro defined, TIMEOUT_CYCLES=16; send 0x11, idle 16 cycles -> timeout pulses once, then 0xA1,0xA2,0xA3,0xA4 -> word_data=0xA1A2A3A4; macro undefined, same stimulus -> timeout=0, word_data=0x11A1A2A3.
